// File: rtl/sram_rr_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_rr_port_ctrl
//
// Shares one single-port RW OpenRAM macro between two requesters. A
// round-robin arbiter grants at most one request per cycle. The granted
// command is registered straight onto the macro pins. Reads come back on a
// fixed two-cycle path to the requester that issued them.
//
// After reset the controller can walk every word to zero (INIT_CLEAR=1).
// Requests are refused until that walk completes.
//
// Optional feature macro: SRAM_CTRL_STATS_EN
//   defined   -> rd_count / wr_count count accepted RUN reads / writes and
//                saturate at 16'hFFFF
//   undefined -> rd_count / wr_count are tied to zero
//
// Ports:
//   clk0                     clock (shared with the macro)
//   rst_n                    asynchronous active-low reset
//   rN_valid/ready           request handshake, N = 0,1 (ready combinational)
//   rN_we/addr/wdata         request command
//   rN_rvalid/rdata          read response, one-cycle pulse, data holds
//   sram_csb0/web0/addr0/din0  registered macro command (active-low selects)
//   sram_dout0               macro read data
//   init_done                clear walk finished (or skipped)
//   rd_count/wr_count        access statistics (optional feature)
// -----------------------------------------------------------------------------
module sram_rr_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst_n,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,

    output logic                  init_done,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    rr_ptr;     // 0: r0 wins a tie, 1: r1 wins a tie

    logic                    run;
    logic                    grant0;
    logic                    grant1;
    logic                    xfer;
    logic                    xfer_we;
    logic [ADDR_WIDTH-1:0]   xfer_addr;
    logic [DATA_WIDTH-1:0]   xfer_wdata;

    logic                    rd_vld_p1;
    logic                    rd_id_p1;
    logic                    rd_vld_p2;
    logic                    rd_id_p2;

    // Arbitration: a lone requester always wins; a tie goes to rr_ptr.
    always_comb begin
        run        = (state == RUN);
        grant0     = run & r0_valid & (~r1_valid | ~rr_ptr);
        grant1     = run & r1_valid & (~r0_valid |  rr_ptr);
        xfer       = grant0 | grant1;
        xfer_we    = grant1 ? r1_we    : r0_we;
        xfer_addr  = grant1 ? r1_addr  : r0_addr;
        xfer_wdata = grant1 ? r1_wdata : r0_wdata;
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // Issue stage: clear walk or accepted command onto the macro pins.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT_CLEAR ? CLEAR : RUN;
            clr_addr   <= '0;
            rr_ptr     <= 1'b0;
            init_done  <= 1'b0;
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    sram_csb0  <= 1'b0;
                    sram_web0  <= 1'b0;
                    sram_addr0 <= clr_addr;
                    sram_din0  <= '0;
                    clr_addr   <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state <= RUN;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    if (xfer) begin
                        sram_csb0  <= 1'b0;
                        sram_web0  <= ~xfer_we;
                        sram_addr0 <= xfer_addr;
                        sram_din0  <= xfer_wdata;
                        // Point at the requester that did not just win.
                        rr_ptr     <= grant0;
                    end else begin
                        sram_csb0  <= 1'b1;
                        sram_web0  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read return: p1 = macro samples command, p2 = dout valid, then capture.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= 1'b0;
            rd_vld_p2 <= 1'b0;
            rd_id_p2  <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            rd_vld_p1 <= xfer & ~xfer_we;
            rd_id_p1  <= grant1;
            rd_vld_p2 <= rd_vld_p1;
            rd_id_p2  <= rd_id_p1;
            r0_rvalid <= rd_vld_p2 & ~rd_id_p2;
            r1_rvalid <= rd_vld_p2 &  rd_id_p2;
            if (rd_vld_p2 && !rd_id_p2) begin
                r0_rdata <= sram_dout0;
            end
            if (rd_vld_p2 && rd_id_p2) begin
                r1_rdata <= sram_dout0;
            end
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (xfer && !xfer_we && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (xfer && xfer_we && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_rr_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_rr_port_ctrl
//
// Directed and random traffic for sram_rr_port_ctrl against a behavioural
// macro. A transaction-level reference model supplies every expected value:
// an array holds the memory contents, a flip bit holds the tie-break
// preference, and per-port slots hold the read returns that are due.
// -----------------------------------------------------------------------------
module tb_sram_rr_port_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk0 = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_valid, r0_we, r1_valid, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          sram_csb0, sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0, sram_dout0;
    logic          init_done;
    logic [15:0]   rd_count, wr_count;

    sram_rr_port_ctrl dut (
        .clk0(clk0), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .init_done(init_done), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk0 = ~clk0;

    // Behavioural single-port macro: samples pins at posedge, acts at negedge.
    logic [DW-1:0] ram [DEPTH];
    logic          s_csb = 1'b1, s_web = 1'b1;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_din = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        sram_dout0 = $urandom;
    end

    always @(posedge clk0) begin
        s_csb  <= sram_csb0;
        s_web  <= sram_web0;
        s_addr <= sram_addr0;
        s_din  <= sram_din0;
    end

    always @(negedge clk0) begin
        if (!s_csb && !s_web) ram[s_addr] <= s_din;
        if (!s_csb &&  s_web) sram_dout0  <= ram[s_addr];
    end

    // Reference model state
    int            n_assert = 0;
    int            n_fail = 0;
    int            rel;           // posedges since reset release
    int            cyc;
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            mdl_ptr;       // requester preferred on a tie
    bit            pend_v [2][8];
    logic [DW-1:0] pend_d [2][8];
    logic [DW-1:0] last_rd [2];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_din;
    int            exp_rd, exp_wr;
    bit            last_g0, last_g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_ptr   = 1'b0;
        rel       = 0;
        exp_rd    = 0;
        exp_wr    = 0;
        last_addr = '0;
        last_din  = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        last_g0   = 1'b0;
        last_g1   = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 8; s++) pend_v[p][s] = 1'b0;
    endtask

    task automatic idle();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic set_req(input int port, input bit we, input int addr, input logic [31:0] data);
        if (port == 0) begin
            r0_valid = 1'b1; r0_we = we; r0_addr = AW'(addr); r0_wdata = data;
        end else begin
            r1_valid = 1'b1; r1_we = we; r1_addr = AW'(addr); r1_wdata = data;
        end
    endtask

    // One clock cycle: check grants, advance the model, check registered outputs.
    task automatic step();
        bit            run, g0, g1, gp, we, exp_csb, exp_web, ev;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            slot;
        #1;
        run = (rel >= DEPTH);
        g0  = run && r0_valid && (!r1_valid || !mdl_ptr);
        g1  = run && r1_valid && (!r0_valid ||  mdl_ptr);
        chk("r0_ready", 32'(r0_ready), 32'(g0));
        chk("r1_ready", 32'(r1_ready), 32'(g1));
        gp = g1;
        we = g1 ? r1_we    : r0_we;
        a  = g1 ? r1_addr  : r0_addr;
        d  = g1 ? r1_wdata : r0_wdata;
        @(posedge clk0);
        cyc++;
        if (!run) begin
            exp_csb = 1'b0; exp_web = 1'b0;
            last_addr = AW'(rel); last_din = '0;
            mdl_mem[rel] = '0;
        end else if (g0 || g1) begin
            exp_csb = 1'b0; exp_web = !we;
            last_addr = a; last_din = d;
            if (we) begin
                mdl_mem[a] = d;
                if (exp_wr < 65535) exp_wr++;
            end else begin
                slot = (cyc + 2) % 8;
                pend_v[gp][slot] = 1'b1;
                pend_d[gp][slot] = mdl_mem[a];
                if (exp_rd < 65535) exp_rd++;
            end
            mdl_ptr = !gp;
        end else begin
            exp_csb = 1'b1; exp_web = 1'b1;
        end
        rel++;
        last_g0 = g0;
        last_g1 = g1;
        @(negedge clk0);
        chk("sram_csb0", 32'(sram_csb0), 32'(exp_csb));
        chk("sram_web0", 32'(sram_web0), 32'(exp_web));
        chk("sram_addr0", 32'(sram_addr0), 32'(last_addr));
        chk("sram_din0", sram_din0, last_din);
        slot = cyc % 8;
        for (int p = 0; p < 2; p++) begin
            ev = pend_v[p][slot];
            if (ev) last_rd[p] = pend_d[p][slot];
            pend_v[p][slot] = 1'b0;
            if (p == 0) begin
                chk("r0_rvalid", 32'(r0_rvalid), 32'(ev));
                chk("r0_rdata", r0_rdata, last_rd[0]);
            end else begin
                chk("r1_rvalid", 32'(r1_rvalid), 32'(ev));
                chk("r1_rdata", r1_rdata, last_rd[1]);
            end
        end
        chk("init_done", 32'(init_done), 32'(rel >= DEPTH + 1));
`ifdef SRAM_CTRL_STATS_EN
        chk("rd_count", 32'(rd_count), 32'(exp_rd));
        chk("wr_count", 32'(wr_count), 32'(exp_wr));
`else
        chk("rd_count", 32'(rd_count), 32'd0);
        chk("wr_count", 32'(wr_count), 32'd0);
`endif
    endtask

    initial begin
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        cyc = 0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

        // Reset state, with both requesters asking to prove ready stays low
        repeat (3) @(negedge clk0);
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        chk("rst_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_web0", 32'(sram_web0), 32'd1);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_din0", sram_din0, 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("rst_r0_rdata", r0_rdata, 32'd0);
        chk("rst_r1_rdata", r1_rdata, 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        idle();
        @(negedge clk0);
        rst_n = 1'b1;

        // Clear walk with requests pending: refused until RUN
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 7'h55;
        repeat (DEPTH) step();
        step();                       // accept r0 read of 0x55
        idle();
        repeat (3) step();

        // Write then read the same address on consecutive accepts
        set_req(0, 1'b1, 3, 32'hDEADBEEF);
        step();
        set_req(0, 1'b0, 3, 32'h0);
        step();
        idle();
        repeat (3) step();

        // Both reading continuously: alternating grants
        set_req(1, 1'b1, 9, 32'hA5A5_0009);
        step();
        idle();
        step();
        set_req(0, 1'b0, 3, 32'h0);
        set_req(1, 1'b0, 9, 32'h0);
        repeat (4) step();
        idle();
        repeat (3) step();

        // r1 preload then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b1, i, 32'h100 + 32'(i));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            set_req(1, 1'b0, i, 32'h0);
            step();
        end
        idle();
        repeat (3) step();

        // Random traffic; a refused request keeps its command
        for (int i = 0; i < 400; i++) begin
            if (!(r0_valid && !last_g0)) begin
                r0_valid = 1'($urandom_range(0, 1));
                r0_we    = 1'($urandom_range(0, 1));
                r0_addr  = AW'($urandom_range(0, 15));
                r0_wdata = $urandom;
            end
            if (!(r1_valid && !last_g1)) begin
                r1_valid = 1'($urandom_range(0, 1));
                r1_we    = 1'($urandom_range(0, 1));
                r1_addr  = AW'($urandom_range(0, 15));
                r1_wdata = $urandom;
            end
            step();
        end
        idle();
        repeat (3) step();

        // Reset one cycle after a read accept: the read must vanish
        set_req(0, 1'b0, 5, 32'h0);
        step();
        idle();
        @(posedge clk0);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        #1;
        chk("midrst_csb0", 32'(sram_csb0), 32'd1);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        @(posedge clk0);
        @(negedge clk0);
        chk("midrst_r0_rvalid_late", 32'(r0_rvalid), 32'd0);
        chk("midrst_r1_rvalid_late", 32'(r1_rvalid), 32'd0);
        rst_n = 1'b1;
        repeat (DEPTH + 3) step();

        // Counters: 3 writes then 5 reads
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 20 + i, 32'h5000 + 32'(i));
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            set_req(1, 1'b0, 20 + i, 32'h0);
            step();
        end
        idle();
        repeat (3) step();
`ifdef SRAM_CTRL_STATS_EN
        chk("final_rd_count", 32'(rd_count), 32'd5);
        chk("final_wr_count", 32'(wr_count), 32'd3);
`else
        chk("final_rd_count", 32'(rd_count), 32'd0);
        chk("final_wr_count", 32'(wr_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rr_port_ctrl.md
Name: sram_rr_port_ctrl

Overview:
- Sequences and shares one single-port RW OpenRAM SRAM macro (clk0/csb0/web0/addr0/din0/dout0) between two requesters.
- Round-robin arbitration; valid/ready request handshake; fixed-latency read response per requester.
- Optional post-reset clear walks every word to zero before requests are accepted.
- Sits between the macro and its two clients; the macro is clocked by the same clk0.

Parameters:
- DATA_WIDTH, 32, word width; matches macro.
- ADDR_WIDTH, 7, address width; matches macro.
- RAM_DEPTH, 1<<ADDR_WIDTH, words walked by the clear sequence.
- INIT_CLEAR, 1, 1 = run the clear walk after reset; 0 = go straight to RUN.

Ports:
- clk0  in  1  clock; also drives the macro.
- rst_n  in  1  asynchronous active-low reset.
- rN_valid  in  1  requester N (N=0,1) request valid.
- rN_ready  out  1  request accepted this cycle.
- rN_we  in  1  1 = write, 0 = read.
- rN_addr  in  ADDR_WIDTH  word address.
- rN_wdata  in  DATA_WIDTH  write data.
- rN_rvalid  out  1  read data valid, one-cycle pulse.
- rN_rdata  out  DATA_WIDTH  read data.
- sram_csb0  out  1  to macro csb0, active low.
- sram_web0  out  1  to macro web0, active low.
- sram_addr0  out  ADDR_WIDTH  to macro addr0.
- sram_din0  out  DATA_WIDTH  to macro din0.
- sram_dout0  in  DATA_WIDTH  from macro dout0.
- init_done  out  1  high once the clear walk has finished (or immediately if INIT_CLEAR=0).
- rd_count  out  16  reads issued (optional feature).
- wr_count  out  16  writes issued (optional feature).

Behaviour:
- Reset values (asynchronous on rst_n low): sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, rN_ready=0, rN_rvalid=0, rN_rdata=0, init_done=0, RR pointer=0, counters=0.
- Reset mid-operation aborts any in-flight read; no rvalid is ever produced for it.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if INIT_CLEAR=1, else RUN.
  - CLEAR: each cycle registers a write (csb0=0, web0=0, din0=0) to address k, k = 0..RAM_DEPTH-1.
  - After writing RAM_DEPTH-1, the FSM enters RUN and init_done rises on the next cycle. The clear takes RAM_DEPTH cycles.
  - rN_ready=0 throughout CLEAR. Clear writes do not increment counters.
- RUN arbitration: rN_ready is combinational and is asserted to at most one requester per cycle.
  - Only one valid: that requester wins.
  - Both valid: the RR pointer picks the winner, and the pointer flips to the other requester after each grant.
  - Neither valid: pointer holds.
  - Transfer occurs when valid & ready at a posedge.
- Issue: the accepted command is registered onto the sram_* outputs at the accepting posedge P.
  - The macro samples it at P+1.
  - With no transfer, sram_csb0=1 and sram_web0=1 are registered; addr0/din0 hold.
- Read latency: the macro drives dout0 after the negedge following P+1.
  - The controller registers sram_dout0 into rN_rdata at P+2 and pulses rN_rvalid for that one cycle, routed to the requester recorded at P.
  - Acceptance to rvalid is 2 cycles.
  - rN_rdata holds its last value between pulses.
- Throughput: one access per cycle. Reads pipeline back-to-back, and rvalid may be asserted every cycle.
- There is no response backpressure; requesters must consume rvalid.
- Write then read of the same address on consecutive accepts returns the new data. The macro writes on the negedge before the following read is sampled, so no bypass is needed.
- Requester inputs must stay stable while valid=1 and ready=0.

Optional Feature:
- SRAM_CTRL_STATS_EN.
- Defined: rd_count/wr_count increment by 1 on each accepted RUN read/write, from either requester, and saturate at 16'hFFFF.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset with INIT_CLEAR=1, then a r0 read of addr 7'h55: init_done rises 128 cycles after reset release plus 1, and r0_rvalid returns rdata=0.
- r0 writes 32'hDEADBEEF to addr 3, next cycle r0 reads addr 3: r0_rvalid 2 cycles after the read accept with rdata=32'hDEADBEEF.
- r0 and r1 both continuously read for 4 cycles: grants alternate r0,r1,r0,r1, and each rN_rvalid returns that port's data 2 cycles after its grant.
- r1 only, 8 back-to-back reads of addr 0..7 preloaded with 0x100+i: r1_rvalid high 8 consecutive cycles with data 0x100..0x107 in order.
- rst_n pulsed low one cycle after a read accept: no rvalid is produced, sram_csb0=1 immediately, and init_done returns to 0.
- With SRAM_CTRL_STATS_EN: 3 writes and 5 reads give wr_count=3 and rd_count=5. Without it, both stay 0.
